execute_cycle: RTL

//  RV32I EX stage: consumes the ID/EX register set, resolves operand forwarding, runs the ALU,

---
 rtl/execute_cycle_pkg.sv | 27 ++
 rtl/execute_cycle_if.sv | 55 +++++
 rtl/execute_cycle_alu.sv | 32 +++
 rtl/execute_cycle.sv | 72 +++++++
 4 files changed

// File: rtl/execute_cycle_pkg.sv
// Shared RV32I execute-stage types: ALU operation codes and forwarding selects.
package execute_cycle_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    // 2'b11 is reserved and behaves like FWD_REG.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/execute_cycle_if.sv
// ID/EX inputs, hazard-unit controls and EX/MEM outputs of the execute stage.
// No valid/ready handshake: the stage accepts a new ID/EX set on every rising clk edge;
// stalls are applied upstream and bubbles are inserted with flush_m.
interface execute_cycle_if;
    import execute_cycle_pkg::*;

    logic [XLEN-1:0] rd_e1;
    logic [XLEN-1:0] rd_e2;
    logic [XLEN-1:0] imm_e;
    logic [XLEN-1:0] pc_e;
    logic [XLEN-1:0] pc4_e;
    logic [4:0]      rd_e;
    logic            branch_result_e;
    logic            jump_e;
    logic            reg_write_e;
    logic [1:0]      write_back_e;
    logic            op_a_sel_e;
    logic            op_b_sel_e;
    logic            load_e;
    logic            store_e;
    logic [3:0]      alu_ctrl_e;
    logic [1:0]      forward_a_e;
    logic [1:0]      forward_b_e;
    logic [XLEN-1:0] alu_fwd_m;
    logic [XLEN-1:0] result_w;
    logic            flush_m;

    logic            pc_src_e;
    logic [XLEN-1:0] pc_target_e;
    logic [XLEN-1:0] alu_result_m;
    logic [XLEN-1:0] write_data_m;
    logic [XLEN-1:0] pc4_m;
    logic [4:0]      rd_m;
    logic            reg_write_m;
    logic            load_m;
    logic            store_m;
    logic [1:0]      write_back_m;

    modport master (
        output rd_e1, rd_e2, imm_e, pc_e, pc4_e, rd_e, branch_result_e, jump_e,
               reg_write_e, write_back_e, op_a_sel_e, op_b_sel_e, load_e, store_e,
               alu_ctrl_e, forward_a_e, forward_b_e, alu_fwd_m, result_w, flush_m,
        input  pc_src_e, pc_target_e, alu_result_m, write_data_m, pc4_m, rd_m,
               reg_write_m, load_m, store_m, write_back_m
    );

    modport slave (
        input  rd_e1, rd_e2, imm_e, pc_e, pc4_e, rd_e, branch_result_e, jump_e,
               reg_write_e, write_back_e, op_a_sel_e, op_b_sel_e, load_e, store_e,
               alu_ctrl_e, forward_a_e, forward_b_e, alu_fwd_m, result_w, flush_m,
        output pc_src_e, pc_target_e, alu_result_m, write_data_m, pc4_m, rd_m,
               reg_write_m, load_m, store_m, write_back_m
    );

endinterface

// File: rtl/execute_cycle_alu.sv
// Combinational RV32I ALU; undefined operation codes produce zero.
module execute_cycle_alu
    import execute_cycle_pkg::*;
(
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;
    assign shamt = op_b[4:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = op_a + op_b;
            ALU_SUB:   result = op_a - op_b;
            ALU_SLL:   result = op_a << shamt;
            ALU_SLT:   result = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  result = {31'd0, op_a < op_b};
            ALU_XOR:   result = op_a ^ op_b;
            ALU_SRL:   result = op_a >> shamt;
            ALU_SRA:   result = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:    result = op_a | op_b;
            ALU_AND:   result = op_a & op_b;
            ALU_PASSB: result = op_b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/execute_cycle.sv
// RV32I EX stage: operand forwarding, ALU, branch/jump redirect and the EX/MEM register.
module execute_cycle
    import execute_cycle_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    execute_cycle_if.slave ex
);

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;

    always_comb begin
        fwd_a = ex.rd_e1;
        case (fwd_sel_e'(ex.forward_a_e))
            FWD_WB:  fwd_a = ex.result_w;
            FWD_MEM: fwd_a = ex.alu_fwd_m;
            default: fwd_a = ex.rd_e1;
        endcase
    end

    always_comb begin
        fwd_b = ex.rd_e2;
        case (fwd_sel_e'(ex.forward_b_e))
            FWD_WB:  fwd_b = ex.result_w;
            FWD_MEM: fwd_b = ex.alu_fwd_m;
            default: fwd_b = ex.rd_e2;
        endcase
    end

    assign op_a = ex.op_a_sel_e ? ex.pc_e  : fwd_a;
    assign op_b = ex.op_b_sel_e ? ex.imm_e : fwd_b;

    execute_cycle_alu u_alu (
        .op_a   (op_a),
        .op_b   (op_b),
        .op     (alu_op_e'(ex.alu_ctrl_e)),
        .result (alu_result)
    );

    // Target comes from the ALU sum for all redirects; clearing bit 0 satisfies JALR
    // and is harmless for branch/JAL targets, which are already even.
    assign ex.pc_src_e    = ex.jump_e | ex.branch_result_e;
    assign ex.pc_target_e = {alu_result[XLEN-1:1], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex.alu_result_m <= '0;
            ex.write_data_m <= '0;
            ex.pc4_m        <= '0;
            ex.rd_m         <= '0;
            ex.reg_write_m  <= 1'b0;
            ex.load_m       <= 1'b0;
            ex.store_m      <= 1'b0;
            ex.write_back_m <= '0;
        end else begin
            ex.alu_result_m <= alu_result;
            ex.write_data_m <= fwd_b;
            ex.pc4_m        <= ex.pc4_e;
            ex.rd_m         <= ex.rd_e;
            // A flushed slot keeps its data but can no longer write anything.
            ex.reg_write_m  <= ex.reg_write_e & ~ex.flush_m;
            ex.load_m       <= ex.load_e & ~ex.flush_m;
            ex.store_m      <= ex.store_e & ~ex.flush_m;
            ex.write_back_m <= ex.flush_m ? 2'b00 : ex.write_back_e;
        end
    end

endmodule
